fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Instruction fetch controller for the 8-bit Harvard CPU. Drives the program memory address, which is combinational: data is valid in the same cycle as the address. It reads the variable-length instruction one byte per cycle (opcode, then 0-2 operand bytes) and presents the assembled instruction to the execute stage with a valid/ready handshake. Accepts PC redirects from execute and sits between program memory and decode/execute.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  1 = fetch enabled; 0 = hold in FETCH_OP, PC frozen
pm_addr  output  8  program memory address (= current PC)
pm_data  input  8  program memory read data (combinational from pm_addr)
redirect_valid  input  1  execute requests PC load
redirect_addr  input  8  new PC
instr_valid  output  1  assembled instruction available
instr_ready  input  1  execute accepts instruction
opcode  output  8  opcode byte
op1  output  8  first operand byte (0 if absent)
op2  output  8  second operand byte (0 if absent)
instr_len  output  2  byte count, 1..3
illegal  output  1  opcode not in table; qualified by instr_valid

Behaviour:
- Length table: 8'h00 NOP=1, 8'h01 ADD=2, 8'h02 SUB=2, 8'h04 MOV reg->addr=3, 8'h05 MOV addr->reg=3, 8'h06 MOV #imm->reg=3, 8'h07 JMP=2, 8'h12 CLR=1. Any other value: length 1, illegal=1.
- Reset (async): pc=RESET_PC, state=FETCH_OP, instr_valid=0, opcode/op1/op2=0, instr_len=0, illegal=0.
- pm_addr = pc at all times.
- States: FETCH_OP, FETCH_B1, FETCH_B2, ISSUE.
- FETCH_OP, run=1:
  - opcode<=pm_data; op1,op2<=0; instr_len and illegal from the table; pc<=pc+1.
  - Next state: len 1 -> ISSUE, else FETCH_B1.
- FETCH_OP, run=0: no state change. run is ignored in the other states, so an instruction in flight always completes.
- FETCH_B1: op1<=pm_data; pc<=pc+1; next state: len 2 -> ISSUE, else FETCH_B2.
- FETCH_B2: op2<=pm_data; pc<=pc+1; next state ISSUE.
- ISSUE: instr_valid=1 (registered, asserted in the ISSUE state only). Outputs are stable while stalled. On instr_ready=1 -> FETCH_OP.
- Latency: an N-byte instruction is valid N cycles after FETCH_OP begins. Minimum cycles per instruction = N+1.
- PC arithmetic is 8-bit modulo: 8'hFF+1 = 8'h00. An instruction may straddle the wrap.
- redirect_valid in any state:
  - pc<=redirect_addr; state<=FETCH_OP; instr_valid drops the next cycle.
  - Any partially fetched instruction is discarded.
  - redirect_valid has priority over every other PC update.
- redirect_valid together with instr_ready in ISSUE: the handshake completes (instruction consumed) and the redirect still loads the PC.
- Reset asserted mid-fetch or mid-ISSUE: immediate return to reset values, no completion.

Optional Feature:
- Macro: FETCH_JMP_FOLD_EN.
- Defined: when a JMP (8'h07) completes FETCH_B1, the sequencer loads pc<=pm_data and returns to FETCH_OP. The JMP is never issued, costs 2 cycles, and instr_valid stays 0. A redirect_valid in that same cycle overrides the fold target.
- Undefined: JMP is issued like any other 2-byte instruction (opcode 8'h07, op1 = target), and execute performs the redirect.

Test Plan:
- Reset, ROM 05 07 02 06 0C 03, ready=1 -> issue {05,07,02,len3} at cycle 3, then {06,0C,03,len3} at cycle 7; pm_addr=6 after the second issue.
- ready held 0 for 5 cycles on first instr -> instr_valid stays 1, opcode/op1/op2 stable, pm_addr stays 3; accept -> fetch resumes at 3.
- redirect_valid=1, addr=8'h20 during FETCH_B1 of a 3-byte instr -> no issue, pm_addr=8'h20 next cycle, next issue fetched from 0x20.
- ROM[0]=8'h03 -> issue opcode 03, len 1, illegal=1, op1=op2=0.
- RESET_PC=8'hFF, ROM[FF]=01, ROM[00]=04 -> ADD issued with op1=04, pm_addr=8'h01.
- FETCH_JMP_FOLD_EN defined, ROM 07 21, ROM[21]=00 -> no JMP issued, NOP issued at cycle 3, pm_addr=8'h22. Undefined -> {07,21,len2} issued.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: program-memory, redirect and issue signals of the fetch sequencer.
interface fetch_sequencer_if;
    logic       run;
    logic [7:0] pm_addr;
    logic [7:0] pm_data;
    logic       redirect_valid;
    logic [7:0] redirect_addr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] opcode;
    logic [7:0] op1;
    logic [7:0] op2;
    logic [1:0] instr_len;
    logic       illegal;
    modport master (
        input  run, pm_data, redirect_valid, redirect_addr, instr_ready,
        output pm_addr, instr_valid, opcode, op1, op2, instr_len, illegal
    );
    modport slave (
        output run, pm_data, redirect_valid, redirect_addr, instr_ready,
        input  pm_addr, instr_valid, opcode, op1, op2, instr_len, illegal
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: byte-serial variable-length instruction fetch with valid/ready issue and PC redirect.
// Define FETCH_JMP_FOLD_EN to resolve JMP inside the fetcher instead of issuing it.
module fetch_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input logic               clk,
    input logic               rst,
    fetch_sequencer_if.master fb
);
    typedef enum logic [1:0] {FETCH_OP, FETCH_B1, FETCH_B2, ISSUE} state_t;
    state_t     state, state_n;
    logic [7:0] pc, pc_n, opcode, opcode_n, op1, op1_n, op2, op2_n;
    logic [1:0] len, len_n, dec_len;
    logic       illegal, illegal_n, dec_illegal;
    always_comb begin
        dec_len     = 2'd1;
        dec_illegal = 1'b0;
        case (fb.pm_data)
            8'h00, 8'h12:        dec_len = 2'd1;
            8'h01, 8'h02, 8'h07: dec_len = 2'd2;
            8'h04, 8'h05, 8'h06: dec_len = 2'd3;
            default:             dec_illegal = 1'b1;
        endcase
    end
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        opcode_n  = opcode;
        op1_n     = op1;
        op2_n     = op2;
        len_n     = len;
        illegal_n = illegal;
        case (state)
            FETCH_OP: if (fb.run) begin
                opcode_n  = fb.pm_data;
                op1_n     = 8'h00;
                op2_n     = 8'h00;
                len_n     = dec_len;
                illegal_n = dec_illegal;
                pc_n      = pc + 8'd1;
                state_n   = (dec_len == 2'd1) ? ISSUE : FETCH_B1;
            end
            FETCH_B1: begin
                op1_n   = fb.pm_data;
                pc_n    = pc + 8'd1;
                state_n = (len == 2'd2) ? ISSUE : FETCH_B2;
`ifdef FETCH_JMP_FOLD_EN
                if (opcode == 8'h07) begin
                    pc_n    = fb.pm_data;
                    state_n = FETCH_OP;
                end
`endif
            end
            FETCH_B2: begin
                op2_n   = fb.pm_data;
                pc_n    = pc + 8'd1;
                state_n = ISSUE;
            end
            ISSUE: state_n = fb.instr_ready ? FETCH_OP : ISSUE;
        endcase
        // A redirect wins over every other PC update and drops any partial fetch.
        if (fb.redirect_valid) begin
            pc_n    = fb.redirect_addr;
            state_n = FETCH_OP;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH_OP;
            pc      <= RESET_PC;
            opcode  <= 8'h00;
            op1     <= 8'h00;
            op2     <= 8'h00;
            len     <= 2'd0;
            illegal <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            opcode  <= opcode_n;
            op1     <= op1_n;
            op2     <= op2_n;
            len     <= len_n;
            illegal <= illegal_n;
        end
    end
    assign fb.pm_addr     = pc;
    assign fb.instr_valid = (state == ISSUE);
    assign fb.opcode      = opcode;
    assign fb.op1         = op1;
    assign fb.op2         = op2;
    assign fb.instr_len   = len;
    assign fb.illegal     = illegal;
endmodule
